// File: rtl/sequencer_fsm_if.sv
// sequencer_fsm_if: host/datapath handshake bundle between the sequencer and its surroundings
interface sequencer_fsm_if #(
  parameter int ITER_W = 8
) ();
  logic              start;
  logic              flag_s;
  logic              flag_z;
  logic              div_done;
  logic [4:0]        state;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter_cnt;
  logic              timeout;
  modport master (
    output start, flag_s, flag_z, div_done,
    input  state, busy, done, iter_cnt, timeout
  );
  modport slave (
    input  start, flag_s, flag_z, div_done,
    output state, busy, done, iter_cnt, timeout
  );
endinterface

// File: rtl/sequencer_fsm.sv
// sequencer_fsm: next-state sequencer for the algorithm datapath; SEQ_TIMEOUT_EN adds the MAX_ITER loop abort
module sequencer_fsm #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input logic           clk,
  input logic           rst_n,
  sequencer_fsm_if.slave bus
);
  typedef enum logic [4:0] {
    IDLE, INIT1, INIT2, INIT3, INIT4,
    CHECK1, CHECK2, CHECK3, CHECK4, CHECK5, CHECK6, CHECK7, CHECK8,
    EXCHANGE1, EXCHANGE2, EXCHANGE3, PRELOOP1, PRELOOP2,
    LOOP1, LOOP2, LOOP3, LOOP4, LOOP5, LOOP6, LOOP7, LOOP8, LOOP9, LOOP10, LOOP11,
    END1, END2, UNUSED
  } state_t;

  logic [4:0]        state_q;
  state_t            state_d;
  logic              busy_q, done_q;
  logic [ITER_W-1:0] iter_q, iter_d;
`ifdef SEQ_TIMEOUT_EN
  logic              timeout_q, timeout_d;
`endif

  // next state: straight-line advance by default, branches only at the decision/wait states
  always_comb begin
    state_d = state_t'(state_q + 5'd1);
    iter_d  = iter_q;
`ifdef SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = bus.start ? INIT1 : IDLE;
        if (bus.start) begin
          iter_d = '0;
`ifdef SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      CHECK4: state_d = bus.flag_z ? END1 : CHECK5;
      CHECK8: state_d = bus.flag_s ? EXCHANGE1 : PRELOOP1;
      LOOP6:  state_d = bus.div_done ? LOOP7 : LOOP6;
      LOOP11: begin
        iter_d  = (iter_q == '1) ? iter_q : iter_q + 1'b1;
        state_d = bus.flag_z ? END1 : LOOP1;
`ifdef SEQ_TIMEOUT_EN
        if (!bus.flag_z && (int'(iter_q) + 1 == MAX_ITER)) begin
          state_d   = END1;
          timeout_d = 1'b1;
        end
`endif
      end
      END2:   state_d = IDLE;
      UNUSED: state_d = IDLE;
      default: ;
    endcase
  end

  // registered state and host-visible status; done marks the IDLE cycle right after END2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == END2);
      iter_q  <= iter_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // sticky abort flag, cleared only by a new run or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= timeout_d;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.state    = state_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter_cnt = iter_q;
endmodule

// File: doc/sequencer_fsm.md
# sequencer_fsm

Next-state sequencer for the algorithm datapath. Holds the 5-bit state register, advances it from `start`, datapath status flags and the divider handshake, and feeds `state` to the combinational `controllogic` decoder, which turns it into the RAM/ALU/DIV/register/mux controls. Also reports run status (busy, done pulse, iteration count) to the host.

## Interface
- `ITER_W`, 8: width of the loop iteration counter.
- `MAX_ITER`, 255: iteration limit; used only when `SEQ_TIMEOUT_EN` is defined.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `flag_s`  in  1  registered sign flag from the datapath (set via SET_S1).
- `flag_z`  in  1  registered zero flag from the datapath (set via SET_Z1).
- `div_done`  in  1  divider result valid.
- `state`  out  5  current state code to `controllogic`.
- `busy`  out  1  high whenever `state` != IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `iter_cnt`  out  ITER_W  number of completed LOOP11 passes in the current run.
- `timeout`  out  1  sticky abort flag; constant 0 when the macro is absent.

## Operation
- State codes:
  - IDLE=0, INIT1..4=1..4, CHECK1..8=5..12, EXCHANGE1..3=13..15.
  - PRELOOP1..2=16..17, LOOP1..11=18..28, END1..2=29..30.
  - Code 31 is unused.
- Transitions:
  - IDLE: go to INIT1 if `start`, else stay.
  - INIT1 to INIT4 advance unconditionally. INIT4 goes to CHECK1.
  - CHECK1 to CHECK3 advance unconditionally.
  - CHECK4: go to END1 if `flag_z` (degenerate operand), else CHECK5.
  - CHECK5 to CHECK7 advance unconditionally.
  - CHECK8: go to EXCHANGE1 if `flag_s` (m<n), else PRELOOP1.
  - EXCHANGE1 to EXCHANGE3 advance; EXCHANGE3 goes to PRELOOP1.
  - PRELOOP1 goes to PRELOOP2, then LOOP1.
  - LOOP1 to LOOP5 advance. LOOP5 is where `controllogic` asserts EN_DIV.
  - LOOP6: hold while `div_done`=0; advance when `div_done`=1.
  - LOOP7 to LOOP10 advance.
  - LOOP11: go to END1 if `flag_z`, else LOOP1. Either way `iter_cnt` increments.
  - END1 goes to END2, then IDLE. `done` is registered high for the first IDLE cycle after END2.
  - Code 31 goes to IDLE on the next edge. No done pulse, no other effect.
- Flags are sampled at the clock edge that ends the decision state (CHECK4, CHECK8, LOOP11). Flag values in any other state are ignored.
- `iter_cnt`:
  - Cleared on the IDLE to INIT1 transition.
  - Increments at LOOP11 and saturates at all ones.
  - Holds its value in IDLE so the host can read it.
- `start` is ignored when not in IDLE. `start` held high through END2 launches a new run directly from IDLE: done pulse cycle, then INIT1.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `busy`=0, `done`=0, `iter_cnt`=0, `timeout`=0.
- `rst_n` low forces all outputs to these values asynchronously, including mid-run. Release is synchronous to the next `clk` edge.
- Latency, counted as busy cycles from the first non-IDLE state, with `div_done` already high in LOOP6:
  - CHECK4 zero-exit path: 10 cycles.
  - One iteration, no exchange: 27 cycles.
  - Exchange taken: +3 cycles.
  - Each extra iteration: +11 cycles.
  - Each divider wait cycle in LOOP6: +1 cycle.
- `done` is high for exactly 1 cycle, with `busy`=0 in that same cycle.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - At LOOP11, if `flag_z`=0 and `iter_cnt`+1 == MAX_ITER, go to END1 instead of LOOP1 and set `timeout`.
  - `timeout` stays set until the next IDLE to INIT1 transition or reset.
- `SEQ_TIMEOUT_EN` undefined:
  - Looping is unbounded.
  - `timeout` is tied to 0.
  - The MAX_ITER comparator is not synthesized.

## Test plan
- Reset, then `start` pulse; `flag_z`=1 at CHECK4 -> state sequence 1,2,3,4,5,6,7,8,29,30,0; busy 10 cycles; done 1 cycle; `iter_cnt`=0.
- `flag_s`=1 at CHECK8; `flag_z`=0, 0, 1 at the successive LOOP11 visits; `div_done` high -> EXCHANGE1-3 visited; 52 busy cycles; `iter_cnt`=3.
- `div_done` low for 5 cycles in LOOP6 -> `state`=23 held 6 cycles, then 24; total busy +5.
- `rst_n` low during LOOP3 -> state=0, busy=0, done=0, iter_cnt=0 immediately; a fresh `start` then runs normally. Also: `start` pulses while busy -> no effect.
- Force state code 31 -> IDLE next cycle, done stays 0.
- With `SEQ_TIMEOUT_EN`, MAX_ITER=4, `flag_z` never set -> END1 after 4th LOOP11; `timeout`=1; `iter_cnt`=4; timeout clears on next start.
